// File: rtl/alu_md.sv
// Execute-stage ALU with valid/ready handshake: single-cycle base and branch ops,
// plus iterative shift-add multiply and restoring divide (RV32M-style semantics).
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             taken,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_SLL    = 5'b00010;
    localparam logic [4:0] OP_SLT    = 5'b00100;
    localparam logic [4:0] OP_SLTU   = 5'b00110;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_SRL    = 5'b01010;
    localparam logic [4:0] OP_SRA    = 5'b01011;
    localparam logic [4:0] OP_OR     = 5'b01100;
    localparam logic [4:0] OP_AND    = 5'b01110;
    localparam logic [4:0] OP_BEQ    = 5'b10000;
    localparam logic [4:0] OP_BNE    = 5'b10010;
    localparam logic [4:0] OP_BLT    = 5'b11000;
    localparam logic [4:0] OP_BGE    = 5'b11010;
    localparam logic [4:0] OP_BLTU   = 5'b11100;
    localparam logic [4:0] OP_BGEU   = 5'b11110;
    localparam logic [4:0] OP_MUL    = 5'b00011;
    localparam logic [4:0] OP_MULH   = 5'b00101;
    localparam logic [4:0] OP_MULHSU = 5'b00111;
    localparam logic [4:0] OP_MULHU  = 5'b01001;
    localparam logic [4:0] OP_DIV    = 5'b01101;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [SW:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               taken_q, taken_d;
    logic               out_valid_q, out_valid_d;

    function automatic logic taken_of(input logic [5:0] o, input logic r0);
        return o[5] | (o[4] & ~o[0] & r0);
    endfunction

    function automatic logic [WIDTH-1:0] flag(input logic f);
        return {{(WIDTH-1){1'b0}}, f};
    endfunction

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] base_res;

    assign accept = in_valid & in_ready;
    assign shamt  = b[SW-1:0];

    always_comb begin
        base_res = '0;
        case (op[4:0])
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = a - b;
            OP_SLL:  base_res = a << shamt;
            OP_SLT:  base_res = flag($signed(a) < $signed(b));
            OP_SLTU: base_res = flag(a < b);
            OP_XOR:  base_res = a ^ b;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = $signed(a) >>> shamt;
            OP_OR:   base_res = a | b;
            OP_AND:  base_res = a & b;
            OP_BEQ:  base_res = flag(a == b);
            OP_BNE:  base_res = flag(a != b);
            OP_BLT:  base_res = flag($signed(a) < $signed(b));
            OP_BGE:  base_res = flag($signed(a) >= $signed(b));
            OP_BLTU: base_res = flag(a < b);
            OP_BGEU: base_res = flag(a >= b);
            default: base_res = '0;
        endcase
    end

    // Operand decode: which ops treat which operand as signed, and magnitudes.
    logic             is_mul, is_div, is_quot, a_sgn, b_sgn, a_neg, b_neg;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag, div_special;

    always_comb begin
        is_mul      = op[4:0] inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        is_div      = op[4:0] inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_quot     = op[4:0] inside {OP_DIV, OP_DIVU};
        a_sgn       = op[4:0] inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn       = op[4:0] inside {OP_MULH, OP_DIV, OP_REM};
        a_neg       = a_sgn & a[WIDTH-1];
        b_neg       = b_sgn & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_zero    = (b == '0);
        div_ovf     = b_sgn & (a == MIN_VAL) & (b == '1);
        div_special = '0;
        if (div_zero)
            div_special = is_quot ? '1 : a;
        else if (div_ovf)
            div_special = is_quot ? MIN_VAL : '0;
    end

    // Iteration datapath: acc_q holds {partial product} or {remainder, quotient}.
    logic [WIDTH:0]     mul_sum;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, done_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q};
        div_diff = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q[4:0])
            OP_MUL:                       done_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: done_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              done_res = quot_fix;
            default:                      done_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        taken_d     = taken_q;
        out_valid_d = out_valid_q & ~out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = op;
                    if (is_mul) begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        neg_d   = a_neg ^ b_neg;
                        cnt_d   = (SW+1)'(WIDTH);
                        state_d = S_MUL;
                    end else if (is_div && !(div_zero || div_ovf)) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        neg_d   = is_quot ? (a_neg ^ b_neg) : a_neg;
                        cnt_d   = (SW+1)'(WIDTH);
                        state_d = S_DIV;
                    end else begin
                        result_d    = is_div ? div_special : base_res;
                        taken_d     = taken_of(op, result_d[0]);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - (SW+1)'(1);
                if (cnt_q == (SW+1)'(1))
                    state_d = S_DONE;
            end
            S_DIV: begin
                acc_d = {(div_ge ? div_diff : acc_q[2*WIDTH-2:WIDTH-1]),
                         acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q - (SW+1)'(1);
                if (cnt_q == (SW+1)'(1))
                    state_d = S_DONE;
            end
            default: begin
                result_d    = done_res;
                taken_d     = taken_of(op_q, done_res[0]);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            taken_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            taken_q     <= taken_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = ~rst & (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign taken     = taken_q;
    assign busy      = (state_q == S_MUL) | (state_q == S_DIV);

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: directed test-plan cases plus randomized ops with random
// back-pressure, checked every cycle against an arithmetic reference model.
module tb_alu_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         taken;
    logic         busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rand_rdy = 1'b0;
    logic rdy_fixed = 1'b1;

    typedef struct {
        logic [W-1:0] res;
        logic         tk;
        int           lat;
        int           acc;
    } exp_t;
    exp_t sb_q[$];

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .taken(taken), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: results straight from 64-bit integer arithmetic.
    function automatic void model(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic t, output int lat);
        longint       sx, sy;
        logic [63:0]  p;
        logic [W-1:0] mn;
        logic         ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        mn  = 32'h8000_0000;
        ovf = (x == mn) && (y == 32'hFFFF_FFFF);
        lat = 1;
        r   = '0;
        case (o[4:0])
            5'h00: r = x + y;
            5'h01: r = x - y;
            5'h02: r = x << y[4:0];
            5'h04: r = {31'b0, sx < sy};
            5'h06: r = {31'b0, x < y};
            5'h08: r = x ^ y;
            5'h0A: r = x >> y[4:0];
            5'h0B: r = $signed(x) >>> y[4:0];
            5'h0C: r = x | y;
            5'h0E: r = x & y;
            5'h10: r = {31'b0, x == y};
            5'h12: r = {31'b0, x != y};
            5'h18: r = {31'b0, sx < sy};
            5'h1A: r = {31'b0, sx >= sy};
            5'h1C: r = {31'b0, x < y};
            5'h1E: r = {31'b0, x >= y};
            5'h03: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0];  lat = W + 2; end
            5'h05: begin p = sx * sy;                 r = p[63:32]; lat = W + 2; end
            5'h07: begin p = sx * longint'({32'b0, y}); r = p[63:32]; lat = W + 2; end
            5'h09: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; lat = W + 2; end
            5'h0D: begin
                if (y == 0)  r = '1;
                else if (ovf) r = mn;
                else begin r = 32'(sx / sy); lat = W + 2; end
            end
            5'h0F: begin
                if (y == 0) r = '1;
                else begin r = x / y; lat = W + 2; end
            end
            5'h11: begin
                if (y == 0)  r = x;
                else if (ovf) r = '0;
                else begin r = 32'(sx % sy); lat = W + 2; end
            end
            5'h13: begin
                if (y == 0) r = x;
                else begin r = x % y; lat = W + 2; end
            end
            default: r = '0;
        endcase
        t = o[5] | (o[4] & ~o[0] & r[0]);
    endfunction

    // Every-cycle compare against the scoreboard front.
    always @(negedge clk) begin
        exp_t e;
        logic ev, eb, win;
        int   age;
        if (rst) begin
            sb_q.delete();
            chkb("rst_out_valid", out_valid, 1'b0);
            chkb("rst_busy", busy, 1'b0);
            chkb("rst_in_ready", in_ready, 1'b0);
            chkw("rst_result", result, '0);
            chkb("rst_taken", taken, 1'b0);
        end else begin
            ev  = 1'b0;
            eb  = 1'b0;
            win = 1'b0;
            if (sb_q.size() > 0) begin
                age = cyc - sb_q[0].acc;
                ev  = (age + 1 >= sb_q[0].lat);
                eb  = (sb_q[0].lat > 1) && (age < W);
                win = (sb_q[0].lat > 1) && (age <= W);
            end
            chkb("out_valid", out_valid, ev);
            chkb("busy", busy, eb);
            chkb("in_ready", in_ready, !win && (!ev || out_ready));
            if (ev) begin
                chkw("result", result, sb_q[0].res);
                chkb("taken", taken, sb_q[0].tk);
                if (out_ready) void'(sb_q.pop_front());
            end
            if (in_valid && in_ready) begin
                model(op, a, b, e.res, e.tk, e.lat);
                e.acc = cyc + 1;
                sb_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int acc);
        logic ok;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        op       = 6'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_out(output int seen);
        seen = -1000;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = cyc;
                break;
            end
        end
        if (seen == -1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_timeout: out_valid stayed 0, expected 1 within 100 cycles");
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]   codes [24];
        logic [W-1:0] r;
        logic         t;
        int           l, acc, acc2, seen;
        logic [4:0]   code;
        codes = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h06, 5'h08, 5'h0A, 5'h0B, 5'h0C, 5'h0E,
                  5'h10, 5'h12, 5'h18, 5'h1A, 5'h1C, 5'h1E,
                  5'h03, 5'h05, 5'h07, 5'h09, 5'h0D, 5'h0F, 5'h11, 5'h13};

        // Pin the reference model with hand-worked values.
        model(6'h05, 32'hFFFF_FFFE, 32'd3, r, t, l);
        chkw("model_mulh", r, 32'hFFFF_FFFF);
        chkw("model_mulh_lat", 32'(l), 32'd34);
        model(6'h07, 32'hFFFF_FFFF, 32'd2, r, t, l);
        chkw("model_mulhsu", r, 32'hFFFF_FFFF);
        model(6'h11, 32'hFFFF_FFF9, 32'd2, r, t, l);
        chkw("model_rem", r, 32'hFFFF_FFFF);
        model(6'h13, 32'd7, 32'd0, r, t, l);
        chkw("model_remu_by0", r, 32'd7);
        chkw("model_remu_by0_lat", 32'(l), 32'd1);
        model(6'h18, 32'hFFFF_FFFF, 32'd1, r, t, l);
        chkb("model_blt_taken", t, 1'b1);
        model(6'h1A, 32'hFFFF_FFFF, 32'd1, r, t, l);
        chkw("model_bge", r, 32'd0);
        chkb("model_bge_taken", t, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chkb("in_ready_after_rst", in_ready, 1'b1);

        send(6'h00, 32'd7, 32'hFFFF_FFFD, acc);
        wait_out(seen);
        chkw("add_latency", 32'(seen - acc + 1), 32'd1);
        chkw("add_result", result, 32'd4);
        chkb("add_taken", taken, 1'b0);

        send(6'h18, 32'hFFFF_FFFF, 32'd1, acc);
        send(6'h1C, 32'hFFFF_FFFF, 32'd1, acc2);
        chkw("b2b_accept_gap", 32'(acc2 - acc), 32'd1);
        wait_out(seen);
        chkw("bltu_result", result, 32'd0);
        chkb("bltu_taken", taken, 1'b0);

        send(6'h20, 32'd100, 32'd4, acc);
        wait_out(seen);
        chkb("jal_taken", taken, 1'b1);
        chkw("jal_result", result, 32'd104);

        send(6'h0B, 32'h8000_0000, 32'hFFFF_FF24, acc);
        wait_out(seen);
        chkw("sra_result", result, 32'hF800_0000);
        send(6'h02, 32'd1, 32'd33, acc);
        wait_out(seen);
        chkw("sll_result", result, 32'd2);

        send(6'h05, 32'hFFFF_FFFE, 32'd3, acc);
        wait_out(seen);
        chkw("mulh_latency", 32'(seen - acc + 1), 32'd34);
        chkw("mulh_result", result, 32'hFFFF_FFFF);
        send(6'h03, 32'hFFFF_FFFE, 32'd3, acc);
        wait_out(seen);
        chkw("mul_result", result, 32'hFFFF_FFFA);

        send(6'h0D, 32'hFFFF_FFF9, 32'd2, acc);
        wait_out(seen);
        chkw("div_latency", 32'(seen - acc + 1), 32'd34);
        chkw("div_result", result, 32'hFFFF_FFFD);
        send(6'h11, 32'hFFFF_FFF9, 32'd2, acc);
        wait_out(seen);
        chkw("rem_result", result, 32'hFFFF_FFFF);

        send(6'h0F, 32'd12345, 32'd0, acc);
        wait_out(seen);
        chkw("divu0_latency", 32'(seen - acc + 1), 32'd1);
        chkw("divu0_result", result, 32'hFFFF_FFFF);
        send(6'h0D, 32'h8000_0000, 32'hFFFF_FFFF, acc);
        wait_out(seen);
        chkw("divovf_latency", 32'(seen - acc + 1), 32'd1);
        chkw("divovf_result", result, 32'h8000_0000);
        send(6'h11, 32'h8000_0000, 32'hFFFF_FFFF, acc);
        wait_out(seen);
        chkw("removf_result", result, 32'd0);

        // Back-pressure: result must hold while the consumer stalls.
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        send(6'h00, 32'd5, 32'd6, acc);
        wait_out(seen);
        for (int k = 0; k < 5; k++) begin
            chkw("hold_result", result, 32'd11);
            chkb("hold_in_ready", in_ready, 1'b0);
            chkb("hold_out_valid", out_valid, 1'b1);
            @(negedge clk);
        end
        rdy_fixed = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a divide aborts it.
        send(6'h0D, 32'd100, 32'd7, acc);
        repeat (10) @(negedge clk);
        chkb("div_busy_before_rst", busy, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chkb("midrst_out_valid", out_valid, 1'b0);
        chkb("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(6'h00, 32'd2, 32'd3, acc);
        wait_out(seen);
        chkw("post_rst_add", result, 32'd5);
        chkw("post_rst_latency", 32'(seen - acc + 1), 32'd1);

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            code = codes[$urandom_range(0, 23)];
            if ($urandom_range(0, 15) == 0) code = 5'($urandom);
            send({($urandom_range(0, 7) == 0), code}, pick_operand(), pick_operand(), acc);
        end
        rand_rdy = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chkw("drain_outstanding", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
